order_book_side: RTL
====================

Name: order_book_side

Overview:
- Parametrised single-side limit order book: stores up to DEPTH resting orders.
- Continuously publishes the best order under price-time priority. Highest price is best when SIDE=1 (bid); lowest price is best when SIDE=0 (ask).
- Accepts ADD, CANCEL and REDUCE requests over a valid/ready handshake and returns a one-cycle status response per request.
- Sits between the feed decoder and the strategy/quote logic; two instances form a full book.

Parameters:
- DEPTH, 1024, maximum resting orders; power of two, >=2.
- ID_W, 32, order id width.
- QTY_W, 32, quantity width.
- PRICE_W, 64, price width (unsigned).
- SIDE, 1, 1 = bid (max price best), 0 = ask (min price best).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_type  in  2  01 ADD, 10 CANCEL, 11 REDUCE, 00 NOP.
- req_id  in  ID_W  order id.
- req_qty  in  QTY_W  ADD: quantity; REDUCE: decrement.
- req_price  in  PRICE_W  ADD price; ignored otherwise.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_status  out  2  00 OK, 01 NOT_FOUND, 10 FULL, 11 REMOVED (REDUCE emptied the order).
- count  out  $clog2(DEPTH)+1  resting order count.
- best_valid  out  1  count != 0.
- best_id  out  ID_W  best order id.
- best_qty  out  QTY_W  best order quantity.
- best_price  out  PRICE_W  best order price.

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE, req_ready=1, rsp_valid=0, rsp_status=0, count=0, best_valid=0, best_id/qty/price=0.
  - Reset aborts any in-flight operation with no response.
  - Storage contents need not be cleared.
- Handshake: a request is accepted on an edge where req_valid & req_ready. Fields are captured at that edge, and req_ready drops the following cycle.
  - req_ready returns high in the same cycle rsp_valid pulses; back-to-back requests are allowed in that cycle.
  - NOP is accepted silently (no rsp_valid, req_ready stays 1).
- Storage: compact array entries[0..count-1] in arrival order; index 0 is the oldest.
- States: IDLE, ADD, SEARCH, SHIFT, RESCAN.
- IDLE --ADD--> ADD; IDLE --CANCEL/REDUCE--> SEARCH.
- ADD (1 cycle):
  - If count==DEPTH: status FULL, no change.
  - Else: write entry at index count, count+1, status OK.
  - If the book was empty, or the new price is strictly better than best_price, update best_*. Equal price never displaces the earlier order.
  - Duplicate ids are not checked.
  - Returns to IDLE.
- SEARCH: compares entry index k against the captured id in cycle k (k=0,1,...).
  - No match after index count-1 (or count==0): status NOT_FOUND, back to IDLE.
  - First match at k for CANCEL: go to SHIFT.
  - REDUCE, stored qty > req_qty: subtract req_qty, status OK. If the matched id equals best_id, best_qty updates in the same cycle. Back to IDLE.
  - REDUCE, stored qty <= req_qty: treated as removal; final status REMOVED; go to SHIFT.
- SHIFT: entries[j] <= entries[j+1], one j per cycle, j=k..count-2; then count-1.
  - If the removed id != best_id: respond (OK / REMOVED), go to IDLE.
  - Else: go to RESCAN.
- RESCAN: scans indices 0..count-1 (new count), one per cycle, using a strict-better compare so the lowest index wins ties.
  - Then best_* is loaded from the scan result, best_valid=(count!=0), response is issued, and the state returns to IDLE.
  - If count==0: best_* cleared to 0.
- Best outputs hold old values until the operation completes and never show partial scan results.
- Price compare is unsigned full-width. Quantity subtraction is QTY_W bits and never underflows.
- rsp_valid is high exactly one cycle per accepted non-NOP request.

Test Plan:
- Reset, then ADD(id=1,qty=100,p=500), ADD(2,50,700), ADD(3,20,700) with SIDE=1 -> all OK, count=3, best=(2,50,700); the tie keeps id 2.
- CANCEL id=9 on that book -> NOT_FOUND after 3 search cycles, book unchanged. CANCEL id=1 -> OK, count=2, best unchanged, entries[0]=id 2.
- CANCEL id=2 (best) -> OK, RESCAN runs, best=(3,20,700). REDUCE id=3 qty=5 -> OK, best_qty=15. REDUCE id=3 qty=15 -> REMOVED, count=0, best_valid=0, best_*=0.
- SIDE=0 instance: ADD prices 900, 400, 400 -> best is the first 400 order. CANCEL it -> best is the second 400 order.
- DEPTH=4: five ADDs -> fifth returns FULL, count=4. Hold req_valid continuously -> every request accepted exactly once and exactly one rsp_valid per request.
- Assert resetn=0 during SHIFT of a CANCEL -> next cycle count=0, best_valid=0, req_ready=1, no rsp_valid for the aborted request.

Source files
------------

// File: rtl/order_book_side_if.sv
// Request/response channel of one order-book side: valid/ready request with
// ADD/CANCEL/REDUCE payload and a one-cycle status strobe back.
interface order_book_side_if #(
  parameter int ID_W    = 32,
  parameter int QTY_W   = 32,
  parameter int PRICE_W = 64
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_type;
  logic [ID_W-1:0]    req_id;
  logic [QTY_W-1:0]   req_qty;
  logic [PRICE_W-1:0] req_price;
  logic               rsp_valid;
  logic [1:0]         rsp_status;

  modport master (
    output req_valid, req_type, req_id, req_qty, req_price,
    input  req_ready, rsp_valid, rsp_status
  );

  modport slave (
    input  req_valid, req_type, req_id, req_qty, req_price,
    output req_ready, rsp_valid, rsp_status
  );
endinterface

// File: rtl/order_book_side.sv
// Single-side limit order book: compact arrival-ordered storage, best order
// under price-time priority, ADD/CANCEL/REDUCE handled by a small FSM.
module order_book_side #(
  parameter int DEPTH   = 1024,
  parameter int ID_W    = 32,
  parameter int QTY_W   = 32,
  parameter int PRICE_W = 64,
  parameter bit SIDE    = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  order_book_side_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     best_valid,
  output logic [ID_W-1:0]          best_id,
  output logic [QTY_W-1:0]         best_qty,
  output logic [PRICE_W-1:0]       best_price
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    REQ_NOP    = 2'b00,
    REQ_ADD    = 2'b01,
    REQ_CANCEL = 2'b10,
    REQ_REDUCE = 2'b11
  } req_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_NOT_FOUND = 2'b01,
    ST_FULL      = 2'b10,
    ST_REMOVED   = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SEARCH,
    S_SHIFT,
    S_RESCAN
  } state_t;

  logic [ID_W-1:0]    id_mem    [DEPTH];
  logic [QTY_W-1:0]   qty_mem   [DEPTH];
  logic [PRICE_W-1:0] price_mem [DEPTH];

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      idx_q;
  logic               is_reduce_q;
  logic [ID_W-1:0]    cap_id_q;
  logic [QTY_W-1:0]   cap_qty_q;
  logic [PRICE_W-1:0] cap_price_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  status_t            rsp_status_q;
  status_t            pend_status_q;
  logic               rm_best_q;
  logic               best_valid_q;
  logic [ID_W-1:0]    best_id_q;
  logic [QTY_W-1:0]   best_qty_q;
  logic [PRICE_W-1:0] best_price_q;
  logic               scan_valid_q;
  logic [ID_W-1:0]    scan_id_q;
  logic [QTY_W-1:0]   scan_qty_q;
  logic [PRICE_W-1:0] scan_price_q;

  logic [ID_W-1:0]    cur_id_d, nxt_id_d;
  logic [QTY_W-1:0]   cur_qty_d, nxt_qty_d;
  logic [PRICE_W-1:0] cur_price_d, nxt_price_d;
  logic [IW-1:0]      nxt_idx_d;
  logic               last_d, match_d, keep_d, full_d, add_better_d, scan_take_d;
  logic [QTY_W-1:0]   red_qty_d;

  logic               wr_en_d;
  logic [IW-1:0]      wr_idx_d;
  logic [ID_W-1:0]    wr_id_d;
  logic [QTY_W-1:0]   wr_qty_d;
  logic [PRICE_W-1:0] wr_price_d;

  always_comb begin
    cur_id_d     = id_mem[idx_q[IW-1:0]];
    cur_qty_d    = qty_mem[idx_q[IW-1:0]];
    cur_price_d  = price_mem[idx_q[IW-1:0]];
    nxt_idx_d    = IW'(idx_q + CW'(1));
    nxt_id_d     = id_mem[nxt_idx_d];
    nxt_qty_d    = qty_mem[nxt_idx_d];
    nxt_price_d  = price_mem[nxt_idx_d];
    last_d       = (idx_q == count_q - CW'(1));
    match_d      = (cur_id_d == cap_id_q);
    keep_d       = (cur_qty_d > cap_qty_q);
    red_qty_d    = cur_qty_d - cap_qty_q;
    full_d       = (count_q == CW'(DEPTH));
    add_better_d = SIDE ? (cap_price_q > best_price_q) : (cap_price_q < best_price_q);
    // Strict compare keeps the lowest index on price ties.
    scan_take_d  = !scan_valid_q ||
                   (SIDE ? (cur_price_d > scan_price_q) : (cur_price_d < scan_price_q));

    wr_en_d    = 1'b0;
    wr_idx_d   = idx_q[IW-1:0];
    wr_id_d    = cur_id_d;
    wr_qty_d   = cur_qty_d;
    wr_price_d = cur_price_d;
    case (state_q)
      S_ADD: begin
        if (!full_d) begin
          wr_en_d    = 1'b1;
          wr_idx_d   = count_q[IW-1:0];
          wr_id_d    = cap_id_q;
          wr_qty_d   = cap_qty_q;
          wr_price_d = cap_price_q;
        end
      end
      S_SEARCH: begin
        if (count_q != '0 && match_d && is_reduce_q && keep_d) begin
          wr_en_d  = 1'b1;
          wr_qty_d = red_qty_d;
        end
      end
      S_SHIFT: begin
        if (!last_d) begin
          wr_en_d    = 1'b1;
          wr_id_d    = nxt_id_d;
          wr_qty_d   = nxt_qty_d;
          wr_price_d = nxt_price_d;
        end
      end
      default: ;
    endcase
    if (!resetn) wr_en_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      id_mem[wr_idx_d]    <= wr_id_d;
      qty_mem[wr_idx_d]   <= wr_qty_d;
      price_mem[wr_idx_d] <= wr_price_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      is_reduce_q   <= 1'b0;
      cap_id_q      <= '0;
      cap_qty_q     <= '0;
      cap_price_q   <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      pend_status_q <= ST_OK;
      rm_best_q     <= 1'b0;
      best_valid_q  <= 1'b0;
      best_id_q     <= '0;
      best_qty_q    <= '0;
      best_price_q  <= '0;
      scan_valid_q  <= 1'b0;
      scan_id_q     <= '0;
      scan_qty_q    <= '0;
      scan_price_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            cap_id_q    <= bus.req_id;
            cap_qty_q   <= bus.req_qty;
            cap_price_q <= bus.req_price;
            is_reduce_q <= (bus.req_type == REQ_REDUCE);
            idx_q       <= '0;
            case (req_t'(bus.req_type))
              REQ_ADD: begin
                state_q     <= S_ADD;
                req_ready_q <= 1'b0;
              end
              REQ_CANCEL, REQ_REDUCE: begin
                state_q     <= S_SEARCH;
                req_ready_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        S_ADD: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          if (full_d) begin
            rsp_status_q <= ST_FULL;
          end else begin
            rsp_status_q <= ST_OK;
            count_q      <= count_q + CW'(1);
            if (!best_valid_q || add_better_d) begin
              best_valid_q <= 1'b1;
              best_id_q    <= cap_id_q;
              best_qty_q   <= cap_qty_q;
              best_price_q <= cap_price_q;
            end
          end
        end

        S_SEARCH: begin
          if (count_q == '0 || (!match_d && last_d)) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_NOT_FOUND;
          end else if (match_d) begin
            if (is_reduce_q && keep_d) begin
              if (best_valid_q && cur_id_d == best_id_q) best_qty_q <= red_qty_d;
              state_q      <= S_IDLE;
              req_ready_q  <= 1'b1;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
            end else begin
              pend_status_q <= is_reduce_q ? ST_REMOVED : ST_OK;
              rm_best_q     <= best_valid_q && (cur_id_d == best_id_q);
              state_q       <= S_SHIFT;
            end
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end

        S_SHIFT: begin
          if (!last_d) begin
            idx_q <= idx_q + CW'(1);
          end else begin
            count_q <= count_q - CW'(1);
            if (rm_best_q) begin
              state_q      <= S_RESCAN;
              idx_q        <= '0;
              scan_valid_q <= 1'b0;
            end else begin
              state_q      <= S_IDLE;
              req_ready_q  <= 1'b1;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= pend_status_q;
            end
          end
        end

        S_RESCAN: begin
          // Scan accumulates privately; best_* is only replaced on the last index.
          if (count_q == '0) begin
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_qty_q   <= '0;
            best_price_q <= '0;
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= pend_status_q;
          end else begin
            if (scan_take_d) begin
              scan_valid_q <= 1'b1;
              scan_id_q    <= cur_id_d;
              scan_qty_q   <= cur_qty_d;
              scan_price_q <= cur_price_d;
            end
            if (last_d) begin
              best_valid_q <= 1'b1;
              best_id_q    <= scan_take_d ? cur_id_d    : scan_id_q;
              best_qty_q   <= scan_take_d ? cur_qty_d   : scan_qty_q;
              best_price_q <= scan_take_d ? cur_price_d : scan_price_q;
              state_q      <= S_IDLE;
              req_ready_q  <= 1'b1;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= pend_status_q;
            end else begin
              idx_q <= idx_q + CW'(1);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign count          = count_q;
  assign best_valid     = best_valid_q;
  assign best_id        = best_id_q;
  assign best_qty       = best_qty_q;
  assign best_price     = best_price_q;

endmodule
